// File: rtl/ds_serializer_if.sv
// ds_serializer byte-in / serial-out bundle.
// Producer side is master; the serializer is slave.
interface ds_serializer_if #(
  parameter int DEPTH = 4
);
  logic [7:0]             din;
  logic                   din_vld;
  logic                   din_rdy;
  logic                   ds;
  logic                   ds_vld;
  logic                   sof;
  logic [$clog2(DEPTH):0] lvl;
  logic                   ovf;

  modport master (
    output din, din_vld,
    input  din_rdy, ds, ds_vld, sof, lvl, ovf
  );

  modport slave (
    input  din, din_vld,
    output din_rdy, ds, ds_vld, sof, lvl, ovf
  );
endinterface

// File: rtl/ds_serializer.sv
// Byte FIFO feeding an MSB-first serial shifter.
// Bytes stream back-to-back; DIV clocks per bit.
module ds_serializer #(
  parameter int   DEPTH = 4,
  parameter int   DIV   = 1,
  parameter logic IDLE  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  ds_serializer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} st_t;

  st_t           st, st_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] lvl;
  logic          ovf;
  logic [7:0]    sr, sr_n;
  logic [2:0]    bi, bi_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ds, ds_n;
  logic          vld, vld_n;
  logic          sof, sof_n;
  logic          rdy, push, pop;
  logic [7:0]    head;

  assign rdy  = lvl < FULL;
  assign push = bus.din_vld && rdy;
  assign head = mem[rp];

  assign bus.din_rdy = rdy;
  assign bus.ds      = ds;
  assign bus.ds_vld  = vld;
  assign bus.sof     = sof;
  assign bus.lvl     = lvl;
  assign bus.ovf     = ovf;

  // FIFO storage; contents are don't-care once pointers reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.din;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      lvl <= lvl + 1'b1;
      else if (pop && !push) lvl <= lvl - 1'b1;
      if (bus.din_vld && !rdy) ovf <= 1'b1;
    end
  end

  // shifter state and registered serial outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st  <= S_IDLE;
      sr  <= '0;
      bi  <= '0;
      cnt <= '0;
      ds  <= IDLE;
      vld <= 1'b0;
      sof <= 1'b0;
    end else begin
      st  <= st_n;
      sr  <= sr_n;
      bi  <= bi_n;
      cnt <= cnt_n;
      ds  <= ds_n;
      vld <= vld_n;
      sof <= sof_n;
    end
  end

  // next-state: hold each bit DIV clocks, reload on the last one
  always_comb begin
    st_n  = st;
    pop   = 1'b0;
    sr_n  = sr;
    bi_n  = bi;
    cnt_n = cnt;
    ds_n  = ds;
    vld_n = vld;
    sof_n = 1'b0;
    unique case (st)
      S_IDLE: begin
        ds_n  = IDLE;
        vld_n = 1'b0;
        if (lvl != '0) pop = 1'b1;
      end
      S_SHIFT: begin
        if (cnt != CMAX) begin
          cnt_n = cnt + 1'b1;
        end else begin
          cnt_n = '0;
          if (bi != 3'd7) begin
            bi_n = bi + 1'b1;
            sr_n = {sr[6:0], 1'b0};
            ds_n = sr[6];
          end else if (lvl != '0) begin
            pop = 1'b1;
          end else begin
            st_n  = S_IDLE;
            ds_n  = IDLE;
            vld_n = 1'b0;
          end
        end
      end
      default: st_n = S_IDLE;
    endcase
    if (pop) begin
      st_n  = S_SHIFT;
      sr_n  = head;
      ds_n  = head[7];
      vld_n = 1'b1;
      sof_n = 1'b1;
      bi_n  = '0;
      cnt_n = '0;
    end
  end
endmodule

// File: tb/tb_ds_serializer.sv
// Directed bench for ds_serializer with a bit scoreboard.
// u0: DEPTH=4 DIV=1, u1: DEPTH=4 DIV=4.
module tb_ds_serializer;
  logic clk;
  logic clr;

  ds_serializer_if #(.DEPTH(4)) b0 ();
  ds_serializer_if #(.DEPTH(4)) b1 ();

  ds_serializer #(.DEPTH(4), .DIV(1), .IDLE(1'b0)) u0 (
    .clk(clk), .clr(clr), .bus(b0)
  );
  ds_serializer #(.DEPTH(4), .DIV(4), .IDLE(1'b0)) u1 (
    .clk(clk), .clr(clr), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  int run  [2];
  int last [2];
  int nv   [2];

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_byte(input int u, input logic [7:0] b,
                             input int d);
    for (int i = 7; i >= 0; i--)
      for (int c = 0; c < d; c++)
        if (u == 0) q0.push_back({(i == 7 && c == 0), b[i]});
        else        q1.push_back({(i == 7 && c == 0), b[i]});
  endtask

  task automatic chk(input int u, input logic v, input logic d,
                     input logic s);
    logic [1:0] e;
    int         n;
    n = (u == 0) ? q0.size() : q1.size();
    if (v) begin
      run[u]++;
      nv[u]++;
      if (n == 0) begin
        cmp($sformatf("u%0d_extra_bit", u), v, 1'b0);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        cmp($sformatf("u%0d_ds", u), d, e[0]);
        cmp($sformatf("u%0d_sof", u), s, e[1]);
      end
    end else begin
      if (run[u] != 0) last[u] = run[u];
      run[u] = 0;
      cmp($sformatf("u%0d_idle_ds", u), {d, s}, 2'b00);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk(0, b0.ds_vld, b0.ds, b0.sof);
    chk(1, b1.ds_vld, b1.ds, b1.sof);
  endtask

  task automatic push0(input logic [7:0] b, input bit exp);
    b0.din     = b;
    b0.din_vld = 1'b1;
    if (exp) expect_byte(0, b, 1);
    tick();
    b0.din_vld = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b);
    b1.din     = b;
    b1.din_vld = 1'b1;
    expect_byte(1, b, 4);
    tick();
    b1.din_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 ||
            b0.ds_vld || b1.ds_vld) && n < 600) begin
      tick();
      n++;
    end
    cmp("drain_in_time", n < 600, 1'b1);
  endtask

  initial begin
    int base;
    run  = '{0, 0};
    last = '{0, 0};
    nv   = '{0, 0};
    clr        = 1'b1;
    b0.din     = '0;
    b0.din_vld = 1'b0;
    b1.din     = '0;
    b1.din_vld = 1'b0;
    tick();
    tick();
    cmp("rst_ds",     b0.ds,      1'b0);
    cmp("rst_vld",    b0.ds_vld,  1'b0);
    cmp("rst_sof",    b0.sof,     1'b0);
    cmp("rst_lvl",    b0.lvl,     0);
    cmp("rst_ovf",    b0.ovf,     1'b0);
    cmp("rst_rdy",    b0.din_rdy, 1'b1);
    clr = 1'b0;
    tick();

    // single byte
    push0(8'hAA, 1);
    cmp("single_lvl1", b0.lvl, 1);
    drain();
    cmp("single_run", last[0], 8);
    cmp("single_lvl0", b0.lvl, 0);

    // back-to-back
    push0(8'h55, 1);
    push0(8'h33, 1);
    drain();
    cmp("b2b_run", last[0], 16);

    // full / overflow
    cmp("pre_ovf", b0.ovf, 1'b0);
    push0(8'h11, 1);
    push0(8'hA1, 1);
    push0(8'hB2, 1);
    push0(8'hC3, 1);
    push0(8'hD4, 1);
    cmp("full_lvl", b0.lvl, 4);
    cmp("full_rdy", b0.din_rdy, 1'b0);
    push0(8'hEE, 0);
    cmp("ovf_set", b0.ovf, 1'b1);
    cmp("ovf_lvl", b0.lvl, 4);
    drain();
    cmp("full_run", last[0], 40);
    cmp("ovf_sticky", b0.ovf, 1'b1);
    cmp("full_rdy_back", b0.din_rdy, 1'b1);

    // divider
    push1(8'hCC);
    drain();
    cmp("div_run", last[1], 32);

    // repeated pattern stream
    push0(8'hAA, 1);
    push0(8'hAA, 1);
    push0(8'hAA, 1);
    drain();
    cmp("pat_run", last[0], 24);

    // reset mid-byte during bit 3 of 8'hCD
    push0(8'hCD, 1);
    push0(8'hA5, 1);
    repeat (4) tick();
    cmp("mid_bit3", b0.ds, 1'b1);
    #2 clr = 1'b1;
    #1;
    cmp("clr_ds",  b0.ds,      1'b0);
    cmp("clr_vld", b0.ds_vld,  1'b0);
    cmp("clr_lvl", b0.lvl,     0);
    cmp("clr_rdy", b0.din_rdy, 1'b1);
    cmp("clr_ovf", b0.ovf,     1'b0);
    q0.delete();
    tick();
    clr = 1'b0;
    base = nv[0];
    repeat (30) tick();
    cmp("post_clr_silent", nv[0] - base, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
